// File: rtl/multimode_ring_counter.sv
// multimode_ring_counter: WIDTH-bit shift counter that runs as a one-hot ring
// or as a Johnson (twisted-ring) counter, in either direction, with enable,
// parallel load and self-correction of illegal states. The wrap and err flags
// are registered one-cycle pulses aligned with the out value they describe.
module multimode_ring_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             err
);

    localparam int unsigned TW = WIDTH - 1;

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] shifted;
    logic [TW-1:0]    trans;
    logic             ring_legal;
    logic             john_legal;
    logic             legal;

    // Start pattern, legality of the current state and the one-step shift.
    always_comb begin
        start      = mode ? '0 : WIDTH'(1);
        ring_legal = (out_q != '0) && ((out_q & (out_q - WIDTH'(1))) == '0);
        // Each set bit of trans marks a boundary between adjacent differing bits;
        // a Johnson code has at most one such boundary.
        trans      = out_q[WIDTH-1:1] ^ out_q[WIDTH-2:0];
        john_legal = ((trans & (trans - TW'(1))) == '0);
        legal      = mode ? john_legal : ring_legal;
        // The bit wrapping around is inverted only in Johnson mode.
        if (dir) begin
            shifted = {out_q[0] ^ mode, out_q[WIDTH-1:1]};
        end else begin
            shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1] ^ mode};
        end
    end

    // Next-state selection: load beats enable; hold clears both flags.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            out_d = load_value;
        end else if (enable) begin
            if (legal) begin
                out_d  = shifted;
                wrap_d = (shifted == start);
            end else begin
                // Correction replaces the shift on this edge.
                out_d = start;
                err_d = 1'b1;
            end
        end
    end

    // State and flag registers with synchronous reset to the mode's start pattern.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q  <= start;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Bench for multimode_ring_counter: three widths (4, 8, 2) share one stimulus
// stream. A sequence-table model predicts every cycle; directed steps pin
// literal values from hand-worked sequences, then a randomized run follows.
module tb_multimode_ring_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        mode;
    logic        dir;
    logic        load;
    logic [31:0] lv;

    logic [3:0] out4;
    logic [7:0] out8;
    logic [1:0] out2;
    logic       wrap4, err4, wrap8, err8, wrap2, err2;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    multimode_ring_counter #(.WIDTH(4)) u4 (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
        .load(load), .load_value(lv[3:0]), .out(out4), .wrap(wrap4), .err(err4)
    );
    multimode_ring_counter #(.WIDTH(8)) u8 (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
        .load(load), .load_value(lv[7:0]), .out(out8), .wrap(wrap8), .err(err8)
    );
    multimode_ring_counter #(.WIDTH(2)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
        .load(load), .load_value(lv[1:0]), .out(out2), .wrap(wrap2), .err(err2)
    );

    logic [63:0] dout  [3];
    logic        dwrap [3];
    logic        derr  [3];
    assign dout[0] = 64'(out4);
    assign dout[1] = 64'(out8);
    assign dout[2] = 64'(out2);
    assign dwrap[0] = wrap4;
    assign dwrap[1] = wrap8;
    assign dwrap[2] = wrap2;
    assign derr[0] = err4;
    assign derr[1] = err8;
    assign derr[2] = err2;

    function automatic int wid(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            default: return 2;
        endcase
    endfunction

    // k-th code of the counting sequence starting from the start pattern.
    function automatic logic [63:0] code_of(input int w, input logic md, input int k);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (!md) return 64'd1 << k;
        if (k <= w) return (64'd1 << k) - 64'd1;
        return mask ^ ((64'd1 << (k - w)) - 64'd1);
    endfunction

    task automatic model_step(input int w, input logic [63:0] cur, input logic rst, ld, en,
                              md, dr, input logic [63:0] v, output logic [63:0] nxt,
                              output logic wr, output logic er);
        int n;
        int idx;
        logic [63:0] st;
        st  = md ? 64'd0 : 64'd1;
        n   = md ? 2 * w : w;
        nxt = cur;
        wr  = 1'b0;
        er  = 1'b0;
        if (rst) begin
            nxt = st;
        end else if (ld) begin
            nxt = v & ((64'd1 << w) - 64'd1);
        end else if (en) begin
            idx = -1;
            for (int k = 0; k < n; k++) if (code_of(w, md, k) == cur) idx = k;
            if (idx < 0) begin
                nxt = st;
                er  = 1'b1;
            end else begin
                nxt = code_of(w, md, dr ? (idx + n - 1) % n : (idx + 1) % n);
                wr  = (nxt == st);
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    logic [63:0] mdl   [3];
    logic        mwrap [3];
    logic        merr  [3];
    logic        valid = 1'b0;

    // Advance the model on each edge, then compare all three DUTs just after it.
    always @(posedge clock) begin
        logic [63:0] n;
        logic        w, e;
        for (int i = 0; i < 3; i++) begin
            model_step(wid(i), mdl[i], reset, load, enable, mode, dir, 64'(lv), n, w, e);
            mdl[i]   = n;
            mwrap[i] = w;
            merr[i]  = e;
        end
        if (reset) valid = 1'b1;
        #1;
        if (valid) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("w%0d_out", wid(i)), dout[i], mdl[i]);
                check($sformatf("w%0d_wrap", wid(i)), 64'(dwrap[i]), 64'(mwrap[i]));
                check($sformatf("w%0d_err", wid(i)), 64'(derr[i]), 64'(merr[i]));
            end
        end
    end

    task automatic tick(input logic r, l, e, m, d, input logic [31:0] v);
        @(negedge clock);
        reset  = r;
        load   = l;
        enable = e;
        mode   = m;
        dir    = d;
        lv     = v;
        @(posedge clock);
        #2;
    endtask

    initial begin
        logic [3:0] ring4 [4];
        logic [3:0] jf    [8];
        logic [3:0] jb    [8];
        logic [3:0] enseq [4];
        logic       enpat [4];
        logic [7:0] r8    [8];
        logic       m, d;

        ring4 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        jf    = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        jb    = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        enseq = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        enpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        r8    = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        reset = 1'b1; load = 1'b0; enable = 1'b0; mode = 1'b0; dir = 1'b0; lv = '0;

        // Ring, toward MSB.
        tick(1, 0, 0, 0, 0, 0);
        check("rst_ring_out", 64'(out4), 64'h1);
        check("rst_ring_flags", 64'({wrap4, err4}), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            check("ring4_out", 64'(out4), 64'(ring4[i]));
            check("ring4_wrap", 64'(wrap4), 64'(i == 3));
        end

        // Johnson, both directions.
        tick(1, 0, 0, 1, 0, 0);
        check("rst_john_out", 64'(out4), 64'h0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, 1, 0, 0);
            check("john_fwd_out", 64'(out4), 64'(jf[i]));
            check("john_fwd_wrap", 64'(wrap4), 64'(i == 7));
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, 1, 1, 0);
            check("john_bwd_out", 64'(out4), 64'(jb[i]));
        end

        // Illegal ring state corrects, then counts normally.
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 32'h6);
        check("load_out", 64'(out4), 64'h6);
        tick(0, 0, 1, 0, 0, 0);
        check("fix_out", 64'(out4), 64'h1);
        check("fix_flags", 64'({wrap4, err4}), 64'b01);
        tick(0, 0, 1, 0, 0, 0);
        check("after_fix_out", 64'(out4), 64'h2);
        check("after_fix_err", 64'(err4), 64'h0);

        // Enable gating.
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, enpat[i], 0, 0, 0);
            check("en_out", 64'(out4), 64'(enseq[i]));
            check("en_flags", 64'({wrap4, err4}), 64'h0);
        end

        // Load beats enable; reset mid-Johnson.
        tick(0, 1, 1, 0, 0, 32'h8);
        check("load_en_out", 64'(out4), 64'h8);
        check("load_en_flags", 64'({wrap4, err4}), 64'h0);
        tick(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 0, 0);
        check("john_mid_out", 64'(out4), 64'h7);
        tick(1, 0, 1, 1, 0, 0);
        check("john_rst_out", 64'(out4), 64'h0);

        // Width 8 ring toward LSB, then a switch to Johnson from 00010000.
        tick(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, 0, 1, 0);
            check("ring8_out", 64'(out8), 64'(r8[i]));
            check("ring8_wrap", 64'(wrap8), 64'(i == 7));
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 1, 0);
        check("ring8_pre_switch", 64'(out8), 64'h10);
        tick(0, 0, 1, 1, 1, 0);
        check("switch_out", 64'(out8), 64'h0);
        check("switch_flags", 64'({wrap8, err8}), 64'b01);

        // Width 2 ring wraps every other advance.
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            check("ring2_out", 64'(out2), (i % 2 == 0) ? 64'h2 : 64'h1);
            check("ring2_wrap", 64'(wrap2), 64'(i % 2 == 1));
        end

        // Randomized run; the compare process checks every cycle.
        m = 1'b0;
        d = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) m = ~m;
            if ($urandom_range(0, 9) == 0) d = ~d;
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) < 7, m, d, $urandom);
        end

        @(negedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multimode_ring_counter.md
# multimode_ring_counter

Parametrised successor to the fixed 4-bit ring counter: a WIDTH-bit shift counter that runs as a one-hot ring or as a Johnson (twisted-ring) counter, shifts in either direction, and supports enable and parallel load. Illegal states are self-corrected. Registered wrap and error flags let downstream sequencers and phase generators count full cycles and detect upset states.

## Interface

- WIDTH, 4, counter width in bits; legal range 2..32
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  advance one step this cycle
- mode  in  1  0 = ring (one-hot), 1 = Johnson
- dir  in  1  0 = shift toward MSB, 1 = shift toward LSB
- load  in  1  parallel load this cycle
- load_value  in  WIDTH  value written by load
- out  out  WIDTH  counter state (registered)
- wrap  out  1  one-cycle pulse: out has just returned to the start pattern by a normal advance
- err  out  1  one-cycle pulse: an illegal state was corrected on this advance

## Operation

- Start pattern START(mode): ring = 1 (bit 0 set only); Johnson = all zeros.
- Priority per rising edge: reset > load > enable > hold.
- Reset: out <= START(mode) using the mode value sampled on that edge; wrap <= 0, err <= 0.
- Load: out <= load_value with no legality check; wrap <= 0, err <= 0; enable ignored.
- Hold (enable=0, load=0): out unchanged; wrap <= 0, err <= 0.
- Advance (enable=1, load=0): check legality of the current out against the current mode.
  - Legal ring: exactly one bit set.
  - Legal Johnson: at most one i in 1..WIDTH-1 with out[i] != out[i-1]. This gives 2*WIDTH codes.
  - Legal, ring, dir=0: out <= {out[W-2:0], out[W-1]}. Ring, dir=1: out <= {out[0], out[W-1:1]}.
  - Legal, Johnson, dir=0: out <= {out[W-2:0], ~out[W-1]}. Johnson, dir=1: out <= {~out[0], out[W-1:1]}.
  - Legal advance: err <= 0. wrap <= 1 iff the new out equals START(mode), else 0.
  - Illegal: out <= START(mode), err <= 1, wrap <= 0. The corrective step replaces the shift; no shift happens on that edge.
- Period: ring = WIDTH advances; Johnson = 2*WIDTH advances; same in both directions.
- Mode or dir changes take effect at the next advance. No reset is required.
  - Switching ring to Johnson from a one-hot state: one-hot values with a single transition (0..01, 10..0) are legal Johnson codes and shift normally. All others correct to 0 with err.
  - Switching Johnson to ring: any non-one-hot code corrects to START with err.
- All-zero state in ring mode and all-ones in ring mode (WIDTH>1) are illegal.
- No combinational path from inputs to outputs.

## Timing

- out, wrap and err are all registered. The new out value, and its wrap/err, appear together one cycle after the sampling edge.
- wrap and err are never both 1. Each is high for exactly one cycle per event. Consecutive advances through START in WIDTH=2 ring mode give wrap every other cycle.
- Reset mid-sequence: out = START(mode) on the edge following reset assertion. Flags clear on that same edge. The count restarts on the first enabled edge after reset deasserts.
- Load and enable both high: load wins, with no shift and no flags.
- Latency from an enable edge to visible out change: one clock.

## Test plan

- WIDTH=4, mode=0, dir=0: reset, then enable held high. out = 0001, 0010, 0100, 1000, 0001. wrap=1 only while out=0001 after the 4th advance. err stays 0.
- WIDTH=4, mode=1, dir=0: out = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. wrap on the 8th advance. Repeat with dir=1: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
- WIDTH=4 ring: load 0110, then one advance -> out=0001, err=1 for one cycle, wrap=0. Next advance -> 0010, err=0.
- Enable toggled 1,0,0,1 in ring mode from 0001 -> out 0010, 0010, 0010, 0100. Flags low during hold.
- load=1 and enable=1 with load_value=1000 -> out=1000, no flags. Reset asserted mid-Johnson at 0111 with mode=1 -> out=0000 on the next edge.
- WIDTH=8 ring, dir=1: from 00000001 -> 10000000, then 01000000. wrap after 8 advances. Mode switched to Johnson at 00010000 -> corrects to 00000000 with err=1.
